// File: rtl/shift_deserializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : shift_deserializer_if
//  Description : Serial-bit input, control and parallel-word output bundle
//                for the shift deserializer. The master drives the serial
//                bits and controls; the slave (deserializer) returns the word.
//  Revision    : 1.0 - initial release
// ============================================================================
interface shift_deserializer_if #(
    parameter int WIDTH = 8
);
    logic             bit_valid;
    logic             bit_in;
    logic             lr;
    logic             abort;
    logic             out_ready;
    logic             clr_ovr;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             busy;
    logic             overrun;

    modport master (
        output bit_valid, bit_in, lr, abort, out_ready, clr_ovr,
        input  out_valid, out_data, busy, overrun
    );

    modport slave (
        input  bit_valid, bit_in, lr, abort, out_ready, clr_ovr,
        output out_valid, out_data, busy, overrun
    );
endinterface
`default_nettype wire

// File: rtl/shift_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : shift_deserializer
//  Description : Serial-to-parallel receiver. Rebuilds WIDTH-bit words from
//                one bit per beat, MSB-first or LSB-first (order latched on the
//                first bit of each word), and holds finished words behind a
//                valid/ready output register with a sticky overrun flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_deserializer #(
    parameter int WIDTH = 8
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    shift_deserializer_if.slave bus
);
    localparam int                 c_cnt_w    = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(WIDTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_sh;
    logic [WIDTH-1:0]   w_sh_nxt;
    logic [WIDTH-1:0]   w_sh_shift;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [c_cnt_w-1:0] w_cnt_inc;
    logic               r_dir;
    logic               w_dir_nxt;
    logic               w_dir_eff;
    logic               w_complete;

    logic               r_out_valid;
    logic               w_out_valid_nxt;
    logic [WIDTH-1:0]   r_out_data;
    logic [WIDTH-1:0]   w_out_data_nxt;
    logic               r_overrun;
    logic               w_overrun_nxt;
    logic               w_drop;

    // State register: assembler, output stage and overrun flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_sh        <= '0;
            r_cnt       <= '0;
            r_dir       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sh        <= w_sh_nxt;
            r_cnt       <= w_cnt_nxt;
            r_dir       <= w_dir_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
            r_overrun   <= w_overrun_nxt;
        end
    end

    // Assembler next state: abort wins over a bit in the same cycle; the
    // shift order comes from lr only on the first bit of a word
    always_comb begin
        w_state_nxt = r_state;
        w_sh_nxt    = r_sh;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir;
        w_complete  = 1'b0;
        w_dir_eff   = (r_state == ST_IDLE) ? bus.lr : r_dir;
        w_sh_shift  = w_dir_eff ? {bus.bit_in, r_sh[WIDTH-1:1]}
                                : {r_sh[WIDTH-2:0], bus.bit_in};
        w_cnt_inc   = r_cnt + 1'b1;

        if (bus.abort) begin
            w_state_nxt = ST_IDLE;
            w_sh_nxt    = '0;
            w_cnt_nxt   = '0;
        end else if (bus.bit_valid) begin
            w_sh_nxt = w_sh_shift;
            if (r_state == ST_IDLE) begin
                w_dir_nxt = bus.lr;
            end
            if (w_cnt_inc == c_cnt_full) begin
                w_complete  = 1'b1;
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end else begin
                w_state_nxt = ST_SHIFT;
                w_cnt_nxt   = w_cnt_inc;
            end
        end
    end

    // Output stage: load a finished word if the register is free or being
    // drained this cycle, otherwise drop it and flag overrun (set beats clear)
    always_comb begin
        w_out_valid_nxt = r_out_valid;
        w_out_data_nxt  = r_out_data;
        w_drop          = w_complete && r_out_valid && !bus.out_ready;

        if (w_complete) begin
            if (!w_drop) begin
                w_out_valid_nxt = 1'b1;
                w_out_data_nxt  = w_sh_shift;
            end
        end else if (r_out_valid && bus.out_ready) begin
            w_out_valid_nxt = 1'b0;
        end

        if (w_drop) begin
            w_overrun_nxt = 1'b1;
        end else if (bus.clr_ovr) begin
            w_overrun_nxt = 1'b0;
        end else begin
            w_overrun_nxt = r_overrun;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.busy      = (r_state == ST_SHIFT);
    assign bus.overrun   = r_overrun;

endmodule
`default_nettype wire
